uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 17 +
 rtl/sync_2ff.sv | 27 ++
 rtl/uart_rx.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states and default frame geometry.
// The transmitter will pick up the same defaults from here.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam int NB_DATA_DEF      = 8;
    localparam int OVERSAMPLING_DEF = 16;
    localparam int SB_TICKS_DEF     = 16;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs, with a configurable reset value.
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: mid-bit sampling, optional parity, framing check.
// Outputs are registered and hold until the next completed frame.
module uart_rx
    import uart_pkg::*;
#(
    parameter int NB_DATA      = NB_DATA_DEF,
    parameter int OVERSAMPLING = OVERSAMPLING_DEF,
    parameter int SB_TICKS     = SB_TICKS_DEF,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_s_tick,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rx_done,
    output logic               o_frame_err,
    output logic               o_parity_err
);

    localparam int SC_MAX = (OVERSAMPLING > SB_TICKS) ? OVERSAMPLING : SB_TICKS;
    localparam int SC_W   = $clog2(SC_MAX);
    localparam int NC_W   = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

    localparam logic [SC_W-1:0] HALF_LAST = SC_W'(OVERSAMPLING / 2 - 1);
    localparam logic [SC_W-1:0] BIT_LAST  = SC_W'(OVERSAMPLING - 1);
    localparam logic [SC_W-1:0] STOP_LAST = SC_W'(SB_TICKS - 1);
    localparam logic [NC_W-1:0] DATA_LAST = NC_W'(NB_DATA - 1);
    localparam logic            ODD_BIT   = 1'(PARITY_ODD);

    logic               rx_s;
    rx_state_e          state_q;
    logic [SC_W-1:0]    s_cnt_q;
    logic [NC_W-1:0]    n_cnt_q;
    logic [NB_DATA-1:0] b_q;
    logic [NB_DATA-1:0] b_d;
    logic               par_err_q;
    logic               par_err_d;
    logic [NB_DATA-1:0] data_q;
    logic               done_q;
    logic               ferr_q;
    logic               perr_q;

    sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_sync_rx (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .d_i     (i_rx),
        .q_o     (rx_s)
    );

    // Line is LSB first, so each new bit enters at the MSB and shifts right.
    assign b_d       = NB_DATA'({rx_s, b_q} >> 1);
    assign par_err_d = ^b_q ^ rx_s ^ ODD_BIT;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= IDLE;
            s_cnt_q   <= '0;
            n_cnt_q   <= '0;
            b_q       <= '0;
            par_err_q <= 1'b0;
            data_q    <= '0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_q   <= START;
                        s_cnt_q   <= '0;
                        par_err_q <= 1'b0;
                    end
                end
                START: begin
                    if (i_s_tick) begin
                        if (s_cnt_q == HALF_LAST) begin
                            s_cnt_q <= '0;
                            n_cnt_q <= '0;
                            state_q <= rx_s ? IDLE : DATA;
                        end else begin
                            s_cnt_q <= s_cnt_q + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (i_s_tick) begin
                        if (s_cnt_q == BIT_LAST) begin
                            s_cnt_q <= '0;
                            b_q     <= b_d;
                            if (n_cnt_q == DATA_LAST) begin
                                state_q <= (PARITY_EN != 0) ? PARITY : STOP;
                            end else begin
                                n_cnt_q <= n_cnt_q + 1'b1;
                            end
                        end else begin
                            s_cnt_q <= s_cnt_q + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (i_s_tick) begin
                        if (s_cnt_q == BIT_LAST) begin
                            s_cnt_q   <= '0;
                            par_err_q <= par_err_d;
                            state_q   <= STOP;
                        end else begin
                            s_cnt_q <= s_cnt_q + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (i_s_tick) begin
                        if (s_cnt_q == STOP_LAST) begin
                            s_cnt_q <= '0;
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                            data_q  <= b_q;
                            ferr_q  <= ~rx_s;
                            perr_q  <= par_err_q;
                        end else begin
                            s_cnt_q <= s_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_data       = data_q;
    assign o_rx_done    = done_q;
    assign o_frame_err  = ferr_q;
    assign o_parity_err = perr_q;

endmodule
